// File: rtl/pipeline_sequencer_pkg.sv
// Shared definitions for the residual-pipeline job sequencer.
//   - seq_state_t   : sequencer FSM states
//   - job_desc_t    : latched job descriptor (ROI base address + tag)
//   - POI_ROWS / POI_COLS / TOTAL_ISSUE : derived constants at default sizing
//   - total_issue() : issue count for an arbitrary sizing
package pipeline_pkg;

    localparam int unsigned DEF_POI_DEPTH    = 4;
    localparam int unsigned DEF_POI_WIDTH    = 4;
    localparam int unsigned DEF_WIN_ROWS     = 32;
    localparam int unsigned DEF_PIPE_LATENCY = 3;
    localparam int unsigned DEF_BASE_W       = 12;
    localparam int unsigned DEF_TAG_W        = 4;

    localparam int unsigned POI_ROWS    = 1 << DEF_POI_DEPTH;
    localparam int unsigned POI_COLS    = 1 << DEF_POI_WIDTH;
    localparam int unsigned TOTAL_ISSUE = POI_ROWS * POI_COLS * DEF_WIN_ROWS;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StRun,
        StDrain,
        StDone
    } seq_state_t;

    typedef struct packed {
        logic [DEF_BASE_W-1:0] base;
        logic [DEF_TAG_W-1:0]  tag;
    } job_desc_t;

    function automatic int unsigned total_issue(input int unsigned depth,
                                                input int unsigned width,
                                                input int unsigned win);
        return (32'd1 << depth) * (32'd1 << width) * win;
    endfunction

endpackage

// File: rtl/pipeline_sequencer_iter_counter.sv
// Three-level nested wrap counter producing the (poi_row, poi_col, w_row) issue tuple.
// w_row is innermost and wraps at WIN_ROWS-1; poi_col and poi_row wrap at their
// power-of-two limits.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   clear_i      : zero all three counters (takes priority over en_i)
//   en_i         : advance by one tuple
//   row_o/col_o/w_row_o : current tuple
//   last_o       : current tuple is the final one of the sequence
module iter_counter
    import pipeline_pkg::*;
#(
    parameter int unsigned ROW_W    = DEF_POI_DEPTH,
    parameter int unsigned COL_W    = DEF_POI_WIDTH,
    parameter int unsigned WIN_ROWS = DEF_WIN_ROWS
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        clear_i,
    input  logic                        en_i,
    output logic [ROW_W-1:0]            row_o,
    output logic [COL_W-1:0]            col_o,
    output logic [$clog2(WIN_ROWS)-1:0] w_row_o,
    output logic                        last_o
);

    localparam int unsigned WR_W = $clog2(WIN_ROWS);

    logic [ROW_W-1:0] row_q, row_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [WR_W-1:0]  w_q, w_d;
    logic             w_last, col_last, row_last;

    assign w_last   = (w_q == WR_W'(WIN_ROWS - 1));
    assign col_last = &col_q;
    assign row_last = &row_q;

    always_comb begin
        row_d = row_q;
        col_d = col_q;
        w_d   = w_q;
        if (clear_i) begin
            row_d = '0;
            col_d = '0;
            w_d   = '0;
        end else if (en_i) begin
            if (w_last) begin
                w_d = '0;
                if (col_last) begin
                    col_d = '0;
                    row_d = row_q + ROW_W'(1);   // wraps naturally at 2^ROW_W
                end else begin
                    col_d = col_q + COL_W'(1);
                end
            end else begin
                w_d = w_q + WR_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            row_q <= '0;
            col_q <= '0;
            w_q   <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
            w_q   <= w_d;
        end
    end

    assign row_o   = row_q;
    assign col_o   = col_q;
    assign w_row_o = w_q;
    assign last_o  = w_last && col_last && row_last;

endmodule

// File: rtl/pipeline_sequencer.sv
// Job-level controller for the 4-stage residual pipeline.
// Accepts job descriptors, issues the full (poi_row, poi_col, w_row) sequence,
// counts writeback retirements, drains, then pulses job_done with the job tag.
// Ports:
//   clk, reset                      : clock, synchronous active-high reset
//   job_valid_i/job_ready_o         : descriptor handshake (job_base_i, job_tag_i)
//   stall_i                         : downstream backpressure
//   retire_i                        : writeback retired one window row
//   pipe_en_o, pipe_clear_o         : pipeline enable / one-cycle flush
//   issue_*_o                       : issue tuple and latched base, qualified by issue_valid_o
//   job_done_o, done_tag_o          : completion pulse and tag
//   busy_o                          : any state but idle
//   err_o                           : sticky, retire seen with nothing outstanding
// The descriptor register uses the package job_desc_t, so BASE_W/TAG_W follow its widths.
module pipeline_sequencer
    import pipeline_pkg::*;
#(
    parameter int unsigned POI_DEPTH    = DEF_POI_DEPTH,
    parameter int unsigned POI_WIDTH    = DEF_POI_WIDTH,
    parameter int unsigned WIN_ROWS     = DEF_WIN_ROWS,
    parameter int unsigned PIPE_LATENCY = DEF_PIPE_LATENCY,
    parameter int unsigned BASE_W       = DEF_BASE_W,
    parameter int unsigned TAG_W        = DEF_TAG_W
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        job_valid_i,
    output logic                        job_ready_o,
    input  logic [BASE_W-1:0]           job_base_i,
    input  logic [TAG_W-1:0]            job_tag_i,
    input  logic                        stall_i,
    input  logic                        retire_i,
    output logic                        pipe_en_o,
    output logic                        pipe_clear_o,
    output logic                        issue_valid_o,
    output logic [BASE_W-1:0]           issue_base_o,
    output logic [POI_DEPTH-1:0]        issue_poi_row_o,
    output logic [POI_WIDTH-1:0]        issue_poi_col_o,
    output logic [$clog2(WIN_ROWS)-1:0] issue_w_row_o,
    output logic                        job_done_o,
    output logic [TAG_W-1:0]            done_tag_o,
    output logic                        busy_o,
    output logic                        err_o
);

    // PIPE_LATENCY is informational: completion is decided by counting retires.
    localparam int unsigned TOTAL = total_issue(POI_DEPTH, POI_WIDTH, WIN_ROWS);
    localparam int unsigned CNT_W = $clog2(TOTAL + 1);

    seq_state_t       state_q;
    job_desc_t        job_q;
    logic [CNT_W-1:0] issued_q, retired_q, retired_d;
    logic             err_q;
    logic             accept, issue, last_tuple, none_outstanding, retire_ok, retire_bad;

    always_comb begin
        job_ready_o   = (state_q == StIdle) || (state_q == StDone);
        pipe_clear_o  = (state_q == StLoad);
        pipe_en_o     = ((state_q == StRun) || (state_q == StDrain)) && !stall_i;
        issue         = (state_q == StRun) && !stall_i;
        issue_valid_o = issue;
        busy_o        = (state_q != StIdle);
        job_done_o    = (state_q == StDone);
        done_tag_o    = job_done_o ? job_q.tag : '0;
        issue_base_o  = job_q.base;
        err_o         = err_q;
    end

    assign accept = job_valid_i && job_ready_o;

    // A retire with nothing outstanding is an error in any state; a legal retire
    // only counts while the pipeline is enabled.
    assign none_outstanding = (issued_q == retired_q);
    assign retire_bad       = retire_i && none_outstanding;
    assign retire_ok        = retire_i && pipe_en_o && !none_outstanding;
    assign retired_d        = retired_q + CNT_W'(retire_ok);

    iter_counter #(
        .ROW_W    (POI_DEPTH),
        .COL_W    (POI_WIDTH),
        .WIN_ROWS (WIN_ROWS)
    ) u_iter (
        .clk     (clk),
        .reset   (reset),
        .clear_i (pipe_clear_o),
        .en_i    (issue),
        .row_o   (issue_poi_row_o),
        .col_o   (issue_poi_col_o),
        .w_row_o (issue_w_row_o),
        .last_o  (last_tuple)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            job_q     <= '0;
            issued_q  <= '0;
            retired_q <= '0;
            err_q     <= 1'b0;
        end else begin
            if (retire_bad) begin
                err_q <= 1'b1;
            end
            retired_q <= retired_d;
            if (issue) begin
                issued_q <= issued_q + CNT_W'(1);
            end
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        job_q   <= '{base: job_base_i, tag: job_tag_i};
                        state_q <= StLoad;
                    end
                end
                StLoad: begin
                    issued_q  <= '0;
                    retired_q <= '0;
                    state_q   <= StRun;
                end
                StRun: begin
                    if (issue && last_tuple) begin
                        state_q <= StDrain;
                    end
                end
                StDrain: begin
                    // Look at the next-state count so done follows the final retire directly.
                    if (retired_d == CNT_W'(TOTAL)) begin
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    if (accept) begin
                        job_q   <= '{base: job_base_i, tag: job_tag_i};
                        state_q <= StLoad;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_pipeline_sequencer.sv
module tb_pipeline_sequencer;

    localparam int TOTAL = 8192;
    localparam logic [12:0] STALL_T  = {4'd3, 4'd7, 5'd12};
    localparam logic [12:0] RESUME_T = {4'd3, 4'd7, 5'd13};
    localparam logic [12:0] LAST_T   = {4'd15, 4'd15, 5'd31};

    logic        clk, reset, job_valid, job_ready, stall, retire;
    logic [11:0] job_base, issue_base;
    logic [3:0]  job_tag, done_tag, poi_row, poi_col;
    logic [4:0]  w_row;
    logic        pipe_en, pipe_clear, issue_valid, job_done, busy, err;

    pipeline_sequencer dut (
        .clk             (clk),
        .reset           (reset),
        .job_valid_i     (job_valid),
        .job_ready_o     (job_ready),
        .job_base_i      (job_base),
        .job_tag_i       (job_tag),
        .stall_i         (stall),
        .retire_i        (retire),
        .pipe_en_o       (pipe_en),
        .pipe_clear_o    (pipe_clear),
        .issue_valid_o   (issue_valid),
        .issue_base_o    (issue_base),
        .issue_poi_row_o (poi_row),
        .issue_poi_col_o (poi_col),
        .issue_w_row_o   (w_row),
        .job_done_o      (job_done),
        .done_tag_o      (done_tag),
        .busy_o          (busy),
        .err_o           (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Bench pipeline: 3-deep delay line, frozen while pipe_en is low.
    logic [2:0] dl = '0;
    bit force_retire = 0;
    int stall_left = 0;
    bit stall_arm = 0;
    int hold_left = 0;
    bit hold_arm = 0;
    bit err_watch = 0;

    int n_issue, first_cyc, n_clear, n_done, n_acc, last_ret_cyc;
    int acc_cyc[4], done_cyc[4], clear_cyc[4];
    logic [3:0]  done_tags[4];
    bit          ready_at_done[4];
    logic [12:0] first_t, last_t;
    logic [11:0] first_base;
    int stall_ok, stall_cycles, resume_n, hold_ok, hold_cycles, err_low;
    bit stall_seen;
    logic [12:0] resume_t[2];

    task automatic clear_stats();
        n_issue = 0; first_cyc = -1; n_clear = 0; n_done = 0; n_acc = 0; last_ret_cyc = -1;
        stall_ok = 0; stall_cycles = 0; resume_n = 0; hold_ok = 0; hold_cycles = 0;
        err_low = 0; stall_seen = 0; first_t = '0; last_t = '0; first_base = '0;
        for (int i = 0; i < 4; i++) begin
            acc_cyc[i] = -1; done_cyc[i] = -1; clear_cyc[i] = -1;
            done_tags[i] = '0; ready_at_done[i] = 0;
        end
        resume_t[0] = '0; resume_t[1] = '0;
    endtask

    // One clock cycle: decide stall and retire, sample outputs, advance the bench pipeline.
    task automatic tick();
        logic [12:0] t;
        if (stall_left > 0) begin
            stall = 1'b1;
            stall_left--;
        end else begin
            stall = 1'b0;
            #1;
            t = {poi_row, poi_col, w_row};
            if (stall_arm && issue_valid === 1'b1 && t == STALL_T) begin
                stall = 1'b1;
                stall_left = 9;
                stall_arm = 0;
            end
        end
        #1;
        if (force_retire) retire = 1'b1;
        else if (hold_left > 0) retire = 1'b0;
        else retire = dl[2] && (pipe_en === 1'b1);
        #1;
        t = {poi_row, poi_col, w_row};
        if (issue_valid === 1'b1) begin
            if (first_cyc < 0) begin
                first_cyc = cyc; first_t = t; first_base = issue_base;
            end
            last_t = t;
            n_issue++;
            if (stall_seen && resume_n < 2) begin
                resume_t[resume_n] = t;
                resume_n++;
            end
        end
        if (stall) begin
            stall_cycles++;
            stall_seen = 1;
            if (pipe_en === 1'b0 && issue_valid === 1'b0 && t == STALL_T) stall_ok++;
        end
        if (hold_left > 0) begin
            hold_cycles++;
            if (busy === 1'b1 && job_done === 1'b0 && issue_valid === 1'b0) hold_ok++;
        end
        if (pipe_clear === 1'b1) begin
            if (n_clear < 4) clear_cyc[n_clear] = cyc;
            n_clear++;
        end
        if (job_done === 1'b1) begin
            if (n_done < 4) begin
                done_cyc[n_done] = cyc;
                done_tags[n_done] = done_tag;
                ready_at_done[n_done] = job_ready;
            end
            n_done++;
        end
        if (job_valid && job_ready === 1'b1) begin
            if (n_acc < 4) acc_cyc[n_acc] = cyc;
            n_acc++;
        end
        if (retire) last_ret_cyc = cyc;
        if (err_watch && err !== 1'b1) err_low++;
        if (hold_left > 0) hold_left--;
        else if (pipe_en === 1'b1) dl = {dl[1:0], issue_valid};
        if (hold_arm && issue_valid === 1'b1 && t == LAST_T) begin
            hold_left = 20;
            hold_arm = 0;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic start_job(input logic [3:0] tag, input logic [11:0] base);
        int a0;
        a0 = n_acc;
        job_valid = 1'b1;
        job_tag = tag;
        job_base = base;
        for (int i = 0; i < 50 && n_acc == a0; i++) tick();
        job_valid = 1'b0;
    endtask

    task automatic wait_done(input int want, output bit ok);
        for (int i = 0; i < 20000 && n_done < want; i++) tick();
        ok = (n_done >= want);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
        checks++;
        if ({job_ready, busy, pipe_en, pipe_clear, issue_valid, job_done, err} !== 7'b1000000) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 1000000",
                     {job_ready, busy, pipe_en, pipe_clear, issue_valid, job_done, err});
        end
        checks++;
        if ({issue_base, poi_row, poi_col, w_row, done_tag} !== 29'd0) begin
            errors++;
            $display("FAIL reset_fields: got %h expected 0",
                     {issue_base, poi_row, poi_col, w_row, done_tag});
        end
    endtask

    task automatic test_single_job();
        bit ok;
        clear_stats();
        start_job(4'd5, 12'h040);
        wait_done(1, ok);
        for (int i = 0; i < 10; i++) tick();
        checks++;
        if (!ok) begin errors++; $display("FAIL single_timeout: got no job_done expected one"); end
        checks++;
        if (n_issue != TOTAL) begin
            errors++; $display("FAIL single_issue_count: got %0d expected %0d", n_issue, TOTAL);
        end
        checks++;
        if (first_t !== 13'd0) begin
            errors++; $display("FAIL single_first_tuple: got %h expected 0", first_t);
        end
        checks++;
        if (last_t !== LAST_T) begin
            errors++; $display("FAIL single_last_tuple: got %h expected %h", last_t, LAST_T);
        end
        checks++;
        if (first_cyc != acc_cyc[0] + 2) begin
            errors++;
            $display("FAIL single_latency: got %0d expected %0d", first_cyc - acc_cyc[0], 2);
        end
        checks++;
        if (first_base !== 12'h040) begin
            errors++; $display("FAIL single_base: got %h expected 040", first_base);
        end
        checks++;
        if (n_done != 1 || done_tags[0] !== 4'd5) begin
            errors++;
            $display("FAIL single_done: got %0d pulses tag %0d expected 1 pulse tag 5",
                     n_done, done_tags[0]);
        end
        checks++;
        if (done_cyc[0] != last_ret_cyc + 1) begin
            errors++;
            $display("FAIL single_done_timing: got %0d expected %0d", done_cyc[0], last_ret_cyc + 1);
        end
        checks++;
        if (busy !== 1'b0 || err !== 1'b0 || job_ready !== 1'b1) begin
            errors++;
            $display("FAIL single_after: got busy=%b err=%b ready=%b expected 0 0 1",
                     busy, err, job_ready);
        end
        checks++;
        if (n_clear != 1 || clear_cyc[0] != acc_cyc[0] + 1) begin
            errors++;
            $display("FAIL single_clear: got %0d pulses at %0d expected 1 at %0d",
                     n_clear, clear_cyc[0], acc_cyc[0] + 1);
        end
    endtask

    task automatic test_stall();
        bit ok;
        clear_stats();
        stall_arm = 1;
        start_job(4'd6, 12'h100);
        wait_done(1, ok);
        stall_arm = 0;
        checks++;
        if (!ok) begin errors++; $display("FAIL stall_timeout: got no job_done expected one"); end
        checks++;
        if (stall_cycles != 10 || stall_ok != 10) begin
            errors++;
            $display("FAIL stall_hold: got %0d held of %0d cycles expected 10 of 10",
                     stall_ok, stall_cycles);
        end
        checks++;
        if (resume_n != 2 || resume_t[0] !== STALL_T || resume_t[1] !== RESUME_T) begin
            errors++;
            $display("FAIL stall_resume: got %h,%h expected %h,%h",
                     resume_t[0], resume_t[1], STALL_T, RESUME_T);
        end
        checks++;
        if (n_issue != TOTAL || done_tags[0] !== 4'd6) begin
            errors++;
            $display("FAIL stall_total: got %0d issues tag %0d expected %0d tag 6",
                     n_issue, done_tags[0], TOTAL);
        end
    endtask

    task automatic test_back_to_back();
        clear_stats();
        job_valid = 1'b1;
        job_tag = 4'd1;
        job_base = 12'h200;
        for (int i = 0; i < 40000 && n_done < 2; i++) begin
            tick();
            if (n_acc == 1) begin job_tag = 4'd2; job_base = 12'h300; end
            if (n_acc >= 2) job_valid = 1'b0;
        end
        job_valid = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        checks++;
        if (n_done != 2 || done_tags[0] !== 4'd1 || done_tags[1] !== 4'd2) begin
            errors++;
            $display("FAIL b2b_done: got %0d pulses tags %0d,%0d expected 2 pulses tags 1,2",
                     n_done, done_tags[0], done_tags[1]);
        end
        checks++;
        if (ready_at_done[0] !== 1'b1 || acc_cyc[1] != done_cyc[0]) begin
            errors++;
            $display("FAIL b2b_accept_in_done: got ready=%b accept at %0d expected 1 at %0d",
                     ready_at_done[0], acc_cyc[1], done_cyc[0]);
        end
        checks++;
        if (n_clear != 2 || clear_cyc[1] != done_cyc[0] + 1) begin
            errors++;
            $display("FAIL b2b_clear: got %0d pulses second at %0d expected 2 second at %0d",
                     n_clear, clear_cyc[1], done_cyc[0] + 1);
        end
        checks++;
        if (n_issue != 2 * TOTAL || n_acc != 2) begin
            errors++;
            $display("FAIL b2b_issues: got %0d issues %0d accepts expected %0d issues 2 accepts",
                     n_issue, n_acc, 2 * TOTAL);
        end
    endtask

    task automatic test_spurious_retire();
        bit ok;
        clear_stats();
        force_retire = 1;
        tick();
        force_retire = 0;
        checks++;
        if (err !== 1'b1) begin errors++; $display("FAIL spurious_err: got %b expected 1", err); end
        err_watch = 1;
        start_job(4'd7, 12'h0C0);
        wait_done(1, ok);
        tick();
        err_watch = 0;
        checks++;
        if (!ok || n_done != 1 || done_tags[0] !== 4'd7 || n_issue != TOTAL) begin
            errors++;
            $display("FAIL spurious_job: got %0d pulses tag %0d %0d issues expected 1 tag 7 %0d",
                     n_done, done_tags[0], n_issue, TOTAL);
        end
        checks++;
        if (err_low != 0 || err !== 1'b1) begin
            errors++;
            $display("FAIL spurious_sticky: got %0d low cycles err=%b expected 0 and 1",
                     err_low, err);
        end
    endtask

    task automatic test_reset_in_drain();
        bit ok;
        clear_stats();
        hold_arm = 1;
        start_job(4'd3, 12'h050);
        for (int i = 0; i < 20000 && hold_left == 0; i++) tick();
        checks++;
        if (hold_left == 0) begin
            errors++; $display("FAIL rdrain_reach: got no final issue expected one");
        end
        for (int i = 0; i < 3; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        dl = '0;
        hold_left = 0;
        hold_arm = 0;
        #1;
        checks++;
        if ({job_ready, busy, job_done, pipe_en, err} !== 5'b10000) begin
            errors++;
            $display("FAIL rdrain_state: got %b expected 10000",
                     {job_ready, busy, job_done, pipe_en, err});
        end
        for (int i = 0; i < 5; i++) tick();
        checks++;
        if (n_done != 0) begin
            errors++; $display("FAIL rdrain_no_done: got %0d pulses expected 0", n_done);
        end
        clear_stats();
        start_job(4'd9, 12'h0A0);
        wait_done(1, ok);
        checks++;
        if (!ok || done_tags[0] !== 4'd9 || n_issue != TOTAL) begin
            errors++;
            $display("FAIL rdrain_next_job: got tag %0d %0d issues expected tag 9 %0d",
                     done_tags[0], n_issue, TOTAL);
        end
    endtask

    task automatic test_drain_withhold();
        bit ok;
        clear_stats();
        hold_arm = 1;
        start_job(4'd11, 12'h0F0);
        wait_done(1, ok);
        hold_arm = 0;
        checks++;
        if (hold_cycles != 20 || hold_ok != 20) begin
            errors++;
            $display("FAIL withhold_drain: got %0d good of %0d cycles expected 20 of 20",
                     hold_ok, hold_cycles);
        end
        checks++;
        if (!ok || done_cyc[0] != last_ret_cyc + 1) begin
            errors++;
            $display("FAIL withhold_done_timing: got %0d expected %0d",
                     done_cyc[0], last_ret_cyc + 1);
        end
        checks++;
        if (done_tags[0] !== 4'd11 || n_issue != TOTAL) begin
            errors++;
            $display("FAIL withhold_job: got tag %0d %0d issues expected tag 11 %0d",
                     done_tags[0], n_issue, TOTAL);
        end
    endtask

    initial begin
        reset = 1'b1;
        job_valid = 1'b0;
        job_base = '0;
        job_tag = '0;
        stall = 1'b0;
        retire = 1'b0;
        clear_stats();
        @(posedge clk);
        #1;
        test_reset();
        test_single_job();
        test_stall();
        test_back_to_back();
        test_spurious_retire();
        test_reset_in_drain();
        test_drain_withhold();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
